// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared encodings for the 8-bit core's memory stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_IN  = 2'b10;
  localparam logic [1:0] MTR_PC  = 2'b11;

  localparam logic [7:0] SP_RESET = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INT2 = 2'd1,
    ST_RTI2 = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
// Module   : mem_stage_if
// Brief    : Data-memory bus between the memory stage and the data RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/sp_unit.sv
// ============================================================================
// Module   : sp_unit
// Brief    : Stack pointer; push decrements, pop increments, both wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sp_unit
  import cpu_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       push,
  input  wire logic       pop,
  output logic [7:0]      sp,
  output logic [7:0]      sp_plus1
);

  logic [7:0] r_sp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= SP_RESET;
    end else if (push) begin
      r_sp <= r_sp - 8'd1;
    end else if (pop) begin
      r_sp <= r_sp + 8'd1;
    end
  end

  assign sp       = r_sp;
  assign sp_plus1 = r_sp + 8'd1;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Memory-access stage: loads/stores, stack frames, output port, MEM/WB.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage
  import cpu_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [7:0] pc_plus1,
  input  wire logic [7:0] IP,
  input  wire logic [7:0] ALU_res,
  input  wire logic [7:0] Rd2,
  input  wire logic [7:0] FW_value,
  input  wire logic [1:0] RegDistidx,
  input  wire logic       MemWrite,
  input  wire logic       RegWrite,
  input  wire logic       IO_Write,
  input  wire logic       isCall,
  input  wire logic       isRet,
  input  wire logic       isRti,
  input  wire logic       int_signal,
  input  wire logic [1:0] MemToReg,
  input  wire logic [3:0] flags_in,
  input  wire logic [7:0] in_port,
  mem_stage_if.master     bus,
  output logic            stall,
  output logic            pc_load,
  output logic [7:0]      pc_target,
  output logic            flags_restore,
  output logic [3:0]      flags_out,
  output logic [7:0]      out_port,
  output logic [7:0]      wb_data,
  output logic [1:0]      wb_rd,
  output logic            wb_regwrite
);

  state_t     r_state, w_next;
  logic       w_push, w_pop;
  logic [7:0] w_sp, w_sp_plus1;
  logic [7:0] w_wb_mux;

  sp_unit u_sp (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .pop      (w_pop),
    .sp       (w_sp),
    .sp_plus1 (w_sp_plus1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // In INT2/RTI2 the held EX/MEM control bits are ignored; only the sequence runs.
  always_comb begin
    w_next        = r_state;
    bus.mem_addr  = ALU_res;
    bus.mem_wdata = Rd2;
    bus.mem_we    = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    stall         = 1'b0;
    pc_load       = 1'b0;
    flags_restore = 1'b0;
    case (r_state)
      ST_INT2: begin
        bus.mem_addr  = w_sp;
        bus.mem_wdata = {4'b0000, flags_in};
        bus.mem_we    = 1'b1;
        w_push        = 1'b1;
        w_next        = ST_IDLE;
      end
      ST_RTI2: begin
        bus.mem_addr = w_sp_plus1;
        w_pop        = 1'b1;
        pc_load      = 1'b1;
        w_next       = ST_IDLE;
      end
      default: begin
        if (int_signal) begin
          bus.mem_addr  = w_sp;
          bus.mem_wdata = IP;
          bus.mem_we    = 1'b1;
          w_push        = 1'b1;
          stall         = 1'b1;
          w_next        = ST_INT2;
        end else if (isRti) begin
          bus.mem_addr  = w_sp_plus1;
          w_pop         = 1'b1;
          flags_restore = 1'b1;
          stall         = 1'b1;
          w_next        = ST_RTI2;
        end else if (isRet) begin
          bus.mem_addr = w_sp_plus1;
          w_pop        = 1'b1;
          pc_load      = 1'b1;
        end else if (isCall) begin
          bus.mem_addr  = w_sp;
          bus.mem_wdata = pc_plus1;
          bus.mem_we    = 1'b1;
          w_push        = 1'b1;
        end else if (MemWrite) begin
          bus.mem_we = 1'b1;
        end
      end
    endcase
  end

  assign pc_target = bus.mem_rdata;
  assign flags_out = bus.mem_rdata[3:0];

  always_comb begin
    case (MemToReg)
      MTR_MEM: w_wb_mux = bus.mem_rdata;
      MTR_IN:  w_wb_mux = in_port;
      MTR_PC:  w_wb_mux = pc_plus1;
      default: w_wb_mux = ALU_res;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port    <= 8'h00;
      wb_data     <= 8'h00;
      wb_rd       <= 2'b00;
      wb_regwrite <= 1'b0;
    end else begin
      if (IO_Write) out_port <= FW_value;
      wb_data     <= w_wb_mux;
      wb_rd       <= RegDistidx;
      wb_regwrite <= RegWrite & ~stall;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage with a RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc_plus1, IP, ALU_res, Rd2, FW_value, in_port;
  logic [1:0] RegDistidx, MemToReg;
  logic       MemWrite, RegWrite, IO_Write, isCall, isRet, isRti, int_signal;
  logic [3:0] flags_in;
  logic       stall, pc_load, flags_restore, wb_regwrite;
  logic [7:0] pc_target, out_port, wb_data;
  logic [3:0] flags_out;
  logic [1:0] wb_rd;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] mem [256];

  mem_stage_if bus ();

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_plus1      (pc_plus1),
    .IP            (IP),
    .ALU_res       (ALU_res),
    .Rd2           (Rd2),
    .FW_value      (FW_value),
    .RegDistidx    (RegDistidx),
    .MemWrite      (MemWrite),
    .RegWrite      (RegWrite),
    .IO_Write      (IO_Write),
    .isCall        (isCall),
    .isRet         (isRet),
    .isRti         (isRti),
    .int_signal    (int_signal),
    .MemToReg      (MemToReg),
    .flags_in      (flags_in),
    .in_port       (in_port),
    .bus           (bus.master),
    .stall         (stall),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .flags_restore (flags_restore),
    .flags_out     (flags_out),
    .out_port      (out_port),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_regwrite   (wb_regwrite)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pc_plus1 = 8'h00; IP = 8'h00; ALU_res = 8'h00; Rd2 = 8'h00;
    FW_value = 8'h00; in_port = 8'h00; RegDistidx = 2'b00; MemToReg = 2'b00;
    MemWrite = 1'b0; RegWrite = 1'b0; IO_Write = 1'b0; isCall = 1'b0;
    isRet = 1'b0; isRti = 1'b0; int_signal = 1'b0; flags_in = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clear_inputs();
    tick();
    chk("rst_stall", {7'b0, stall}, 8'h00);
    chk("rst_pc_load", {7'b0, pc_load}, 8'h00);
    chk("rst_mem_we", {7'b0, bus.mem_we}, 8'h00);
    chk("rst_flags_restore", {7'b0, flags_restore}, 8'h00);
    chk("rst_wb_regwrite", {7'b0, wb_regwrite}, 8'h00);
    chk("rst_wb_data", wb_data, 8'h00);
    chk("rst_out_port", out_port, 8'h00);
    chk("rst_sp", dut.u_sp.sp, 8'hFF);
    rst = 1'b0;
    tick();

    // CALL then RET
    isCall = 1'b1; pc_plus1 = 8'h23; #1;
    chk("call_we", {7'b0, bus.mem_we}, 8'h01);
    chk("call_addr", bus.mem_addr, 8'hFF);
    chk("call_wdata", bus.mem_wdata, 8'h23);
    tick();
    chk("call_mem", mem[8'hFF], 8'h23);
    chk("call_sp", dut.u_sp.sp, 8'hFE);
    clear_inputs(); isRet = 1'b1; #1;
    chk("ret_pc_load", {7'b0, pc_load}, 8'h01);
    chk("ret_target", pc_target, 8'h23);
    chk("ret_we", {7'b0, bus.mem_we}, 8'h00);
    tick();
    chk("ret_sp", dut.u_sp.sp, 8'hFF);

    // Interrupt entry
    clear_inputs(); int_signal = 1'b1; IP = 8'h40; flags_in = 4'hA; #1;
    chk("int1_stall", {7'b0, stall}, 8'h01);
    chk("int1_addr", bus.mem_addr, 8'hFF);
    chk("int1_wdata", bus.mem_wdata, 8'h40);
    tick();
    chk("int1_mem", mem[8'hFF], 8'h40);
    chk("int2_stall", {7'b0, stall}, 8'h00);
    chk("int2_addr", bus.mem_addr, 8'hFE);
    chk("int2_wdata", bus.mem_wdata, 8'h0A);
    tick();
    chk("int2_mem", mem[8'hFE], 8'h0A);
    chk("int2_sp", dut.u_sp.sp, 8'hFD);

    // RTI
    clear_inputs(); isRti = 1'b1; #1;
    chk("rti1_stall", {7'b0, stall}, 8'h01);
    chk("rti1_flags_restore", {7'b0, flags_restore}, 8'h01);
    chk("rti1_flags_out", {4'h0, flags_out}, 8'h0A);
    chk("rti1_pc_load", {7'b0, pc_load}, 8'h00);
    tick();
    chk("rti2_flags_restore", {7'b0, flags_restore}, 8'h00);
    chk("rti2_pc_load", {7'b0, pc_load}, 8'h01);
    chk("rti2_target", pc_target, 8'h40);
    chk("rti2_stall", {7'b0, stall}, 8'h00);
    tick();
    chk("rti_sp", dut.u_sp.sp, 8'hFF);
    chk("rti_done_pc_load", {7'b0, pc_load}, 8'h00);

    // Store then load
    clear_inputs(); MemWrite = 1'b1; ALU_res = 8'h10; Rd2 = 8'h5C; #1;
    chk("st_we", {7'b0, bus.mem_we}, 8'h01);
    chk("st_addr", bus.mem_addr, 8'h10);
    tick();
    chk("st_mem", mem[8'h10], 8'h5C);
    clear_inputs(); ALU_res = 8'h10; MemToReg = MTR_MEM; RegDistidx = 2'd2; RegWrite = 1'b1; #1;
    chk("ld_we", {7'b0, bus.mem_we}, 8'h00);
    chk("ld_addr", bus.mem_addr, 8'h10);
    tick();
    chk("ld_wb_data", wb_data, 8'h5C);
    chk("ld_wb_rd", {6'b0, wb_rd}, 8'h02);
    chk("ld_wb_regwrite", {7'b0, wb_regwrite}, 8'h01);

    // Output port and in_port write-back
    clear_inputs(); IO_Write = 1'b1; FW_value = 8'h7E; MemToReg = MTR_IN; in_port = 8'h33;
    tick();
    chk("io_out_port", out_port, 8'h7E);
    chk("in_wb_data", wb_data, 8'h33);
    clear_inputs(); FW_value = 8'h11; MemToReg = MTR_ALU; ALU_res = 8'h9B;
    tick();
    chk("io_hold_out_port", out_port, 8'h7E);
    chk("alu_wb_data", wb_data, 8'h9B);

    // Interrupt wins over RTI; the stall cycle writes back a bubble
    clear_inputs(); int_signal = 1'b1; isRti = 1'b1; RegWrite = 1'b1; IP = 8'h55; #1;
    chk("intrti_stall", {7'b0, stall}, 8'h01);
    chk("intrti_flags_restore", {7'b0, flags_restore}, 8'h00);
    chk("intrti_we", {7'b0, bus.mem_we}, 8'h01);
    chk("intrti_wdata", bus.mem_wdata, 8'h55);
    tick();
    chk("bubble_wb_regwrite", {7'b0, wb_regwrite}, 8'h00);
    chk("intrti_int2_addr", bus.mem_addr, 8'hFE);
    chk("intrti_int2_we", {7'b0, bus.mem_we}, 8'h01);

    // Reset asserted in INT2 aborts immediately
    clear_inputs(); rst = 1'b1; #1;
    chk("abort_state", {6'b0, dut.r_state}, {6'b0, ST_IDLE});
    chk("abort_sp", dut.u_sp.sp, 8'hFF);
    chk("abort_stall", {7'b0, stall}, 8'h00);
    chk("abort_we", {7'b0, bus.mem_we}, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    // CALL forwards RegWrite and pc_plus1 to write-back
    isCall = 1'b1; pc_plus1 = 8'h77; RegWrite = 1'b1; MemToReg = MTR_PC; RegDistidx = 2'd3;
    tick();
    chk("call_wb_data", wb_data, 8'h77);
    chk("call_wb_rd", {6'b0, wb_rd}, 8'h03);
    chk("call_wb_regwrite", {7'b0, wb_regwrite}, 8'h01);
    chk("call2_sp", dut.u_sp.sp, 8'hFE);

    // SP wrap: 254 more pushes reach 00, one more wraps to FF
    clear_inputs(); isCall = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    chk("wrap_sp_00", dut.u_sp.sp, 8'h00);
    chk("wrap_addr_00", bus.mem_addr, 8'h00);
    tick();
    chk("wrap_sp_ff", dut.u_sp.sp, 8'hFF);
    clear_inputs(); isRet = 1'b1; #1;
    chk("wrap_pop_addr", bus.mem_addr, 8'h00);
    tick();
    chk("wrap_pop_sp", dut.u_sp.sp, 8'h00);
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 8-bit pipelined core, fed directly by the EX/MEM pipeline register and driving the MEM/WB results to write-back. Performs data loads and stores, stack push/pop for CALL, RET, interrupt entry and RTI, and drives the registered output port. It contains the stack pointer and a small sequencer for the two-word interrupt and RTI transfers, stalling the upstream pipeline for one cycle while those run.

## Interface
- No parameters; widths fixed at 8-bit data and address.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_plus1`  in  8  return address pushed by CALL.
- `IP`  in  8  interrupted PC pushed on interrupt entry.
- `ALU_res`  in  8  load/store address, or ALU result for write-back.
- `Rd2`  in  8  store data.
- `FW_value`  in  8  output-port data.
- `RegDistidx`  in  2  destination register index.
- `MemWrite`, `RegWrite`, `IO_Write`, `isCall`, `isRet`, `isRti`, `int_signal`  in  1 each  control from EX/MEM.
- `MemToReg`  in  2  write-back source select: 00 ALU_res, 01 memory, 10 in_port, 11 pc_plus1.
- `flags_in`  in  4  current CCR, pushed on interrupt.
- `in_port`  in  8  external input port.
- `mem_rdata`  in  8  data memory read data, combinational read.
- `mem_addr`  out  8  data memory address, combinational.
- `mem_wdata`  out  8  data memory write data, combinational.
- `mem_we`  out  1  data memory write enable, combinational.
- `stall`  out  1  holds the IF through EX/MEM registers this cycle.
- `pc_load`  out  1  single-cycle pulse that redirects the PC to `pc_target`.
- `pc_target`  out  8  return address popped by RET or RTI.
- `flags_restore`  out  1  single-cycle pulse that loads `flags_out` into the CCR.
- `flags_out`  out  4  popped flags, equal to `mem_rdata[3:0]`.
- `out_port`  out  8  registered output port.
- `wb_data`  out  8  registered MEM/WB write-back data.
- `wb_rd`  out  2  registered MEM/WB destination index.
- `wb_regwrite`  out  1  registered MEM/WB write enable.

## Operation
- `SP` is an 8-bit register. Push writes `mem[SP]` and then sets `SP` to SP-1. Pop reads `mem[SP+1]` and then sets `SP` to SP+1. Both wrap modulo 256 with no overflow detection.
- Operations in priority order:
  1. `int_signal`
  2. `isRti`
  3. `isRet`
  4. `isCall`
  5. `MemWrite` / load
- FSM states are IDLE, INT2 and RTI2.
- IDLE with `int_signal`:
  - Push `IP` and assert `stall`.
  - Next state is INT2.
- INT2:
  - Push `{4'b0, flags_in}`.
  - `stall` is low and the next state is IDLE.
  - The interrupt vector fetch belongs to the fetch stage, not to this block.
- IDLE with `isRti`:
  - Pop the flags and assert `flags_restore` and `stall`.
  - Next state is RTI2.
- RTI2:
  - Pop into `pc_target` and assert `pc_load`.
  - Next state is IDLE.
- In INT2 and RTI2 the inputs are the held EX/MEM values. Their control bits are ignored apart from the sequence already in progress.
- `isRet`: pop into `pc_target` and assert `pc_load`, single cycle.
- `isCall`: push `pc_plus1`, single cycle.
- `MemWrite`: `mem[ALU_res]` is written with `Rd2`.
- Load (`MemToReg` = 01): `mem_addr` = `ALU_res`.
- With no memory operation, `mem_addr` = `ALU_res` and `mem_we` = 0.
- `IO_Write`: `out_port` takes `FW_value` on the clock edge. This is independent of the stack operations.
- MEM/WB register:
  - Captures the `MemToReg` mux result, `RegDistidx` and `RegWrite` every cycle.
  - In a cycle with `stall` high it captures a bubble: `wb_regwrite` = 0.
  - `isCall` and `isRet` forward their `RegWrite` unchanged.

## Timing
- Reset values:
  - `SP` = 8'hFF and state = IDLE.
  - `out_port`, `wb_data`, `wb_rd` and `wb_regwrite` are 0.
  - `stall`, `pc_load`, `flags_restore` and `mem_we` are 0.
- `mem_*`, `stall`, `pc_load`, `pc_target`, `flags_restore` and `flags_out` are combinational from the state and the current inputs.
- `wb_*`, `out_port` and `SP` are registered with 1-cycle latency.
- Interrupt entry and RTI each take exactly 2 cycles, with `stall` high only in the first.
- RET, CALL, load and store each take 1 cycle.
- Reset asserted mid-sequence (INT2 or RTI2) aborts to IDLE with `SP` = 8'hFF. A partially pushed frame is discarded.
- `int_signal` together with `isRti` in IDLE: the interrupt wins. RTI waits until it is re-presented after the stall.

## Structure
- Shared package `cpu_pkg` holds:
  - the `MemToReg` encoding constants;
  - `SP_RESET` = 8'hFF;
  - the FSM state encoding.
- One sub-module, `sp_unit`, holds the `SP` register and takes push/pop strobes. It presents `SP` and `SP+1` as outputs.
- Address/data muxing, the FSM, the output port and the MEM/WB register live in `mem_stage`.

## Test plan
- Reset, then CALL with `pc_plus1` = 8'h23: mem[FF] = 23, `SP` = FE. A following RET gives `pc_load` = 1, `pc_target` = 23 and `SP` = FF.
- Interrupt with `IP` = 8'h40 and `flags_in` = 4'hA:
  - cycle 1: `stall` = 1 and mem[FF] = 40;
  - cycle 2: mem[FE] = 0A and `SP` = FD.
  - A later RTI pulses `flags_restore` with `flags_out` = A, then `pc_load` with `pc_target` = 40, and `SP` returns to FF.
- Store `Rd2` = 5C at `ALU_res` = 10, then load from 10 with `MemToReg` = 01 and `RegDistidx` = 2: `wb_data` = 5C and `wb_rd` = 2 one cycle later.
- `IO_Write` with `FW_value` = 8'h7E: `out_port` = 7E after one edge. `MemToReg` = 10 with `in_port` = 33 gives `wb_data` = 33.
- `SP` wrap and reset:
  - set `SP` = 00 via 255 pushes, push once more: `SP` = FF;
  - assert `rst` during INT2: state is IDLE, `SP` = FF and `stall` = 0 immediately.
